// File: rtl/gcd_seq_pkg.sv
// Shared definitions for the GCD job sequencer.
// Holds the sequencer state encoding, the slave CSR word map, the register
// offsets of the downstream GCD calculator and the CTRL bit positions.
package gcd_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_RD_A      = 4'd1,
        S_RD_B      = 4'd2,
        S_WR_A      = 4'd3,
        S_WR_B      = 4'd4,
        S_POLL      = 4'd5,
        S_POLL_WAIT = 4'd6,
        S_RD_RES    = 4'd7,
        S_RES_WAIT  = 4'd8,
        S_WR_RES    = 4'd9,
        S_NEXT      = 4'd10
    } seq_state_e;

    // Slave CSR word addresses
    localparam logic [1:0] CSR_CTRL  = 2'd0;
    localparam logic [1:0] CSR_SRC   = 2'd1;
    localparam logic [1:0] CSR_DST   = 2'd2;
    localparam logic [1:0] CSR_COUNT = 2'd3;

    // GCD calculator register offsets; offset 1 is operand A on write and
    // the result on read
    localparam logic [1:0] GCD_REG_STATUS = 2'd0;
    localparam logic [1:0] GCD_REG_A_RES  = 2'd1;
    localparam logic [1:0] GCD_REG_B      = 2'd2;

    // CTRL bit positions
    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_BUSY_BIT   = 0;
    localparam int CTRL_DONE_BIT   = 1;
    localparam int CTRL_ERROR_BIT  = 2;
    localparam int CTRL_IRQ_EN_BIT = 3;
    localparam int CTRL_JOBS_LSB   = 16;

    // Saturating view of the 32-bit job counter for the 16-bit CTRL field
    function automatic logic [15:0] jobs_sat(input logic [31:0] jobs);
        return (jobs > 32'h0000_FFFF) ? 16'hFFFF : jobs[15:0];
    endfunction

endpackage

// File: rtl/gcd_job_sequencer_if.sv
// Avalon-MM style memory bus used by the sequencer's memory master.
// Signals: address (byte), read, write, writedata, readdata, waitrequest.
// Modports: master (sequencer side), slave (memory side).
interface gcd_job_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              waitrequest;

    modport master (
        output address, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/gcd_seq_mem_port.sv
// Single-command memory master port.
// A start_i pulse captures one read or write command, which is presented on
// the bus (registered) and held until waitrequest drops; the port then
// returns a one-cycle ack_o, with the read data on rdata_o for reads.
// Ports: clock, reset (sync, active-high), start_i, we_i, addr_i, wdata_i,
//        ack_o, rdata_o, mem_bus (master modport).
module gcd_seq_mem_port #(
    parameter int ADDR_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [31:0]         wdata_i,
    output logic                ack_o,
    output logic [31:0]         rdata_o,
    gcd_job_sequencer_if.master mem_bus
);

    logic [ADDR_W-1:0] addr_q;
    logic              rd_q;
    logic              wr_q;
    logic [31:0]       wdata_q;
    logic              ack_q;
    logic [31:0]       rdata_q;

    // Command capture, hold-while-stalled and completion ack
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= 32'd0;
            ack_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ack_q <= 1'b0;
            if (rd_q || wr_q) begin
                if (!mem_bus.waitrequest) begin
                    rd_q  <= 1'b0;
                    wr_q  <= 1'b0;
                    ack_q <= 1'b1;
                    if (rd_q) begin
                        rdata_q <= mem_bus.readdata;
                    end
                end
            end else if (start_i) begin
                addr_q  <= addr_i;
                rd_q    <= ~we_i;
                wr_q    <= we_i;
                wdata_q <= wdata_i;
            end
        end
    end

    assign mem_bus.address   = addr_q;
    assign mem_bus.read      = rd_q;
    assign mem_bus.write     = wr_q;
    assign mem_bus.writedata = wdata_q;
    assign ack_o             = ack_q;
    assign rdata_o           = rdata_q;

endmodule

// File: rtl/gcd_job_sequencer.sv
// GCD job sequencer: batch-feeds operand pairs from memory into a GCD
// calculator through its CSR slave and stores the results back to memory.
// Ports: clock, reset (sync, active-high); csr_* slave (CTRL/SRC/DST/COUNT);
//        mem (memory master interface); gcd_* master towards the GCD CSRs.
// Optional: GCD_SEQ_IRQ_EN adds a level irq output and CTRL bit3 irq_enable,
//           with write-1-to-clear of done (bit1) and error (bit2).
module gcd_job_sequencer
    import gcd_seq_pkg::*;
#(
    parameter int POLL_LIMIT = 1024,
    parameter int ADDR_W     = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                csr_read,
    input  logic                csr_write,
    input  logic [1:0]          csr_address,
    input  logic [31:0]         csr_writedata,
    output logic [31:0]         csr_readdata,
    gcd_job_sequencer_if.master mem,
    output logic [1:0]          gcd_address,
    output logic                gcd_read,
    output logic                gcd_write,
    output logic [31:0]         gcd_writedata,
    input  logic [31:0]         gcd_readdata
`ifdef GCD_SEQ_IRQ_EN
    ,
    output logic                irq
`endif
);

    localparam int PCNT_W = $clog2(POLL_LIMIT + 1);

    seq_state_e        state_q, state_d;
    logic [31:0]       src_q, dst_q, count_q;
    logic              done_q, done_d, error_q, error_d;
    logic [31:0]       jobs_q, jobs_d;
    logic [PCNT_W-1:0] poll_q, poll_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [31:0]       csr_readdata_q, rdata_s;
    logic [1:0]        gcd_address_q, gcd_address_d;
    logic              gcd_read_q, gcd_read_d, gcd_write_q, gcd_write_d;
    logic [31:0]       gcd_writedata_q, gcd_writedata_d;
    logic              busy_s, start_s, ctrl_wr_s, clr_done_s, clr_error_s;
    logic              irq_en_s;
    logic              mem_start_s, mem_we_s, mem_ack_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [31:0]       mem_wdata_s, mem_rdata_s;

    assign busy_s    = (state_q != S_IDLE);
    assign ctrl_wr_s = csr_write && (csr_address == CSR_CTRL);
    assign start_s   = ctrl_wr_s && csr_writedata[CTRL_START_BIT];

`ifdef GCD_SEQ_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q;
    assign irq_en_d    = ctrl_wr_s ? csr_writedata[CTRL_IRQ_EN_BIT] : irq_en_q;
    assign clr_done_s  = ctrl_wr_s && csr_writedata[CTRL_DONE_BIT];
    assign clr_error_s = ctrl_wr_s && csr_writedata[CTRL_ERROR_BIT];
    assign irq_en_s    = irq_en_q;
    assign irq         = irq_q;

    // irq enable register and registered level interrupt
    always_ff @(posedge clock) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_en_d & (done_d | error_d);
        end
    end
`else
    assign clr_done_s  = 1'b0;
    assign clr_error_s = 1'b0;
    assign irq_en_s    = 1'b0;
`endif

    // Configuration registers, writable only while idle
    always_ff @(posedge clock) begin
        if (reset) begin
            src_q   <= 32'd0;
            dst_q   <= 32'd0;
            count_q <= 32'd0;
        end else if (csr_write && !busy_s) begin
            case (csr_address)
                CSR_SRC:   src_q   <= csr_writedata;
                CSR_DST:   dst_q   <= csr_writedata;
                CSR_COUNT: count_q <= csr_writedata;
                default:   ;
            endcase
        end
    end

    // Sequencer next-state, per-job datapath and memory command issue
    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        error_d     = error_q;
        jobs_d      = jobs_q;
        poll_d      = poll_q;
        a_d         = a_q;
        b_d         = b_q;
        mem_start_s = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = '0;
        mem_wdata_s = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    jobs_d  = 32'd0;
                    if (count_q != 32'd0) begin
                        state_d     = S_RD_A;
                        mem_start_s = 1'b1;
                        mem_addr_s  = ADDR_W'(src_q);
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_A: begin
                if (mem_ack_s) begin
                    a_d         = mem_rdata_s;
                    state_d     = S_RD_B;
                    mem_start_s = 1'b1;
                    mem_addr_s  = ADDR_W'(src_q) + ADDR_W'({jobs_q, 3'b100});
                end else begin
                    state_d = S_RD_A;
                end
            end
            S_RD_B: begin
                if (mem_ack_s) begin
                    b_d     = mem_rdata_s;
                    state_d = S_WR_A;
                end else begin
                    state_d = S_RD_B;
                end
            end
            S_WR_A: state_d = S_WR_B;
            S_WR_B: begin
                poll_d  = '0;
                state_d = S_POLL;
            end
            S_POLL: state_d = S_POLL_WAIT;
            S_POLL_WAIT: begin
                if (gcd_readdata == 32'd0) begin
                    state_d = S_RD_RES;
                end else if (poll_q + PCNT_W'(1) == PCNT_W'(POLL_LIMIT)) begin
                    poll_d  = poll_q + PCNT_W'(1);
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    poll_d  = poll_q + PCNT_W'(1);
                    state_d = S_POLL;
                end
            end
            S_RD_RES: state_d = S_RES_WAIT;
            S_RES_WAIT: begin
                // The result is captured straight into the memory port
                state_d     = S_WR_RES;
                mem_start_s = 1'b1;
                mem_we_s    = 1'b1;
                mem_addr_s  = ADDR_W'(dst_q) + ADDR_W'({jobs_q, 2'b00});
                mem_wdata_s = gcd_readdata;
            end
            S_WR_RES: begin
                if (mem_ack_s) begin
                    state_d = S_NEXT;
                end else begin
                    state_d = S_WR_RES;
                end
            end
            S_NEXT: begin
                jobs_d = jobs_q + 32'd1;
                if (jobs_q + 32'd1 == count_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d     = S_RD_A;
                    mem_start_s = 1'b1;
                    mem_addr_s  = ADDR_W'(src_q) + ADDR_W'({jobs_q + 32'd1, 3'b000});
                end
            end
            default: state_d = S_IDLE;
        endcase
        done_d  = done_d & ~clr_done_s;
        error_d = error_d & ~clr_error_s;
    end

    // GCD strobes decoded from the next state so they leave a register
    always_comb begin
        gcd_write_d     = 1'b0;
        gcd_read_d      = 1'b0;
        gcd_address_d   = GCD_REG_STATUS;
        gcd_writedata_d = 32'd0;
        case (state_d)
            S_WR_A: begin
                gcd_write_d     = 1'b1;
                gcd_address_d   = GCD_REG_A_RES;
                gcd_writedata_d = a_d;
            end
            S_WR_B: begin
                gcd_write_d     = 1'b1;
                gcd_address_d   = GCD_REG_B;
                gcd_writedata_d = b_d;
            end
            S_POLL:   gcd_read_d = 1'b1;
            S_RD_RES: begin
                gcd_read_d    = 1'b1;
                gcd_address_d = GCD_REG_A_RES;
            end
            default: gcd_read_d = 1'b0;
        endcase
    end

    // CSR read mux; CTRL always reflects live status
    always_comb begin
        rdata_s = 32'd0;
        case (csr_address)
            CSR_CTRL: begin
                rdata_s[CTRL_BUSY_BIT]                   = busy_s;
                rdata_s[CTRL_DONE_BIT]                   = done_q;
                rdata_s[CTRL_ERROR_BIT]                  = error_q;
                rdata_s[CTRL_IRQ_EN_BIT]                 = irq_en_s;
                rdata_s[CTRL_JOBS_LSB+15:CTRL_JOBS_LSB]  = jobs_sat(jobs_q);
            end
            CSR_SRC:   rdata_s = src_q;
            CSR_DST:   rdata_s = dst_q;
            CSR_COUNT: rdata_s = count_q;
            default:   rdata_s = 32'd0;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            jobs_q          <= 32'd0;
            poll_q          <= '0;
            a_q             <= 32'd0;
            b_q             <= 32'd0;
            csr_readdata_q  <= 32'd0;
            gcd_address_q   <= 2'd0;
            gcd_read_q      <= 1'b0;
            gcd_write_q     <= 1'b0;
            gcd_writedata_q <= 32'd0;
        end else begin
            state_q         <= state_d;
            done_q          <= done_d;
            error_q         <= error_d;
            jobs_q          <= jobs_d;
            poll_q          <= poll_d;
            a_q             <= a_d;
            b_q             <= b_d;
            csr_readdata_q  <= csr_read ? rdata_s : 32'd0;
            gcd_address_q   <= gcd_address_d;
            gcd_read_q      <= gcd_read_d;
            gcd_write_q     <= gcd_write_d;
            gcd_writedata_q <= gcd_writedata_d;
        end
    end

    assign csr_readdata  = csr_readdata_q;
    assign gcd_address   = gcd_address_q;
    assign gcd_read      = gcd_read_q;
    assign gcd_write     = gcd_write_q;
    assign gcd_writedata = gcd_writedata_q;

    gcd_seq_mem_port #(
        .ADDR_W (ADDR_W)
    ) u_mem_port (
        .clock   (clock),
        .reset   (reset),
        .start_i (mem_start_s),
        .we_i    (mem_we_s),
        .addr_i  (mem_addr_s),
        .wdata_i (mem_wdata_s),
        .ack_o   (mem_ack_s),
        .rdata_o (mem_rdata_s),
        .mem_bus (mem)
    );

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Bench for gcd_job_sequencer: memory slave with optional random stalls,
// behavioural GCD calculator (with a stuck-busy mode), and directed plus
// randomized batches compared against results computed by Euclid's rule.
module tb_gcd_job_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_read, csr_write;
    logic [1:0]  csr_address;
    logic [31:0] csr_writedata, csr_readdata;
    logic [1:0]  gcd_address;
    logic        gcd_read, gcd_write;
    logic [31:0] gcd_writedata, gcd_rdata;
`ifdef GCD_SEQ_IRQ_EN
    logic        irq;
`endif

    gcd_job_sequencer_if #(.ADDR_W(32)) mem_if ();

    gcd_job_sequencer #(.POLL_LIMIT(4), .ADDR_W(32)) u_dut (
        .clock         (clk),
        .reset         (rst),
        .csr_read      (csr_read),
        .csr_write     (csr_write),
        .csr_address   (csr_address),
        .csr_writedata (csr_writedata),
        .csr_readdata  (csr_readdata),
        .mem           (mem_if),
        .gcd_address   (gcd_address),
        .gcd_read      (gcd_read),
        .gcd_write     (gcd_write),
        .gcd_writedata (gcd_writedata),
        .gcd_readdata  (gcd_rdata)
`ifdef GCD_SEQ_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, t;
        x = a; y = b;
        while (y != 32'd0) begin
            t = x % y; x = y; y = t;
        end
        return x;
    endfunction

    // Memory model: source words written by the stimulus, results captured
    logic [31:0] src_arr [0:1023];
    logic [31:0] dst_arr [0:1023];
    logic        stall_en = 1'b0;
    logic        mem_wait = 1'b0;
    assign mem_if.readdata    = src_arr[mem_if.address[11:2]];
    assign mem_if.waitrequest = mem_wait;

    always @(negedge clk) mem_wait = stall_en ? ($urandom_range(0, 1) == 1) : 1'b0;

    // GCD calculator model
    logic        stuck = 1'b0;
    logic [31:0] g_a, g_res;
    logic        g_busy = 1'b0;
    int          g_lat = 0;
    always @(posedge clk) begin
        if (g_lat > 0) begin
            g_lat <= g_lat - 1;
            if (g_lat == 1) g_busy <= 1'b0;
        end
        if (gcd_write && gcd_address == 2'd1) g_a <= gcd_writedata;
        if (gcd_write && gcd_address == 2'd2) begin
            g_res  <= ref_gcd(g_a, gcd_writedata);
            g_busy <= 1'b1;
            g_lat  <= $urandom_range(1, 3);
        end
        if (gcd_read && gcd_address == 2'd0)      gcd_rdata <= {31'd0, g_busy | stuck};
        else if (gcd_read && gcd_address == 2'd1) gcd_rdata <= g_res;
        else                                      gcd_rdata <= 32'd0;
    end

    // Bus monitors
    int n_mem_wr = 0, n_poll = 0, n_strobe_cyc = 0, overlap_viol = 0, both_viol = 0, stall_viol = 0;
    logic        prev_stall = 1'b0, prev_rd, prev_wr;
    logic [31:0] prev_addr, prev_wd;
    always @(posedge clk) begin
        if (!rst) begin
            if (mem_if.write && !mem_if.waitrequest) begin
                dst_arr[mem_if.address[11:2]] <= mem_if.writedata;
                n_mem_wr++;
            end
            if (gcd_read && gcd_address == 2'd0) n_poll++;
            if (mem_if.read || mem_if.write || gcd_read || gcd_write) n_strobe_cyc++;
            if ((mem_if.read || mem_if.write) && (gcd_read || gcd_write)) overlap_viol++;
            if (gcd_read && gcd_write) both_viol++;
            if (prev_stall && (mem_if.address !== prev_addr || mem_if.read !== prev_rd ||
                               mem_if.write !== prev_wr || mem_if.writedata !== prev_wd))
                stall_viol++;
        end
        prev_stall <= (mem_if.read || mem_if.write) && mem_if.waitrequest && !rst;
        prev_addr  <= mem_if.address;
        prev_rd    <= mem_if.read;
        prev_wr    <= mem_if.write;
        prev_wd    <= mem_if.writedata;
    end

    int n_total = 0, n_pass = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        csr_write = 1'b1; csr_address = a; csr_writedata = d;
        @(negedge clk);
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        csr_read = 1'b1; csr_address = a;
        @(negedge clk);
        csr_read = 1'b0;
        d = csr_readdata;
    endtask

    task automatic run_batch(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
        csr_wr(2'd1, s);
        csr_wr(2'd2, d);
        csr_wr(2'd3, n);
        csr_wr(2'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] v;
        int n;
        n = 0;
        do begin
            csr_rd(2'd0, v);
            n++;
        end while (v[0] && n < 3000);
        check(tag, {31'd0, v[0]}, 32'd0);
    endtask

    initial begin
        logic [31:0] v, pa [4], pb [4];
        int snap_a, snap_b;

        rst = 1'b1; csr_read = 1'b0; csr_write = 1'b0; csr_address = 2'd0; csr_writedata = 32'd0;
        for (int i = 0; i < 1024; i++) src_arr[i] = 32'd0;
        src_arr[64] = 32'd48;   src_arr[65] = 32'd18;
        src_arr[66] = 32'd17;   src_arr[67] = 32'd5;
        src_arr[68] = 32'd1000; src_arr[69] = 32'd250;
        src_arr[80] = 32'd84;   src_arr[81] = 32'd36;
        repeat (4) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_strobes", {28'd0, mem_if.read, mem_if.write, gcd_read, gcd_write}, 32'd0);
        check("rst_rdata", csr_readdata, 32'd0);
        csr_rd(2'd0, v); check("rst_ctrl", v, 32'd0);
        csr_rd(2'd1, v); check("rst_src", v, 32'd0);
        csr_rd(2'd3, v); check("rst_count", v, 32'd0);

        // Directed table of three jobs
        snap_a = n_mem_wr;
        run_batch(32'h100, 32'h800, 32'd3);
        wait_idle("t1_idle");
        check("t1_dst0", dst_arr[512], 32'd6);
        check("t1_dst1", dst_arr[513], 32'd1);
        check("t1_dst2", dst_arr[514], 32'd250);
        csr_rd(2'd0, v); check("t1_ctrl", v, 32'h0003_0002);
        check("t1_wr_cnt", n_mem_wr - snap_a, 32'd3);

        // COUNT = 0: done at once, no bus activity
        csr_wr(2'd3, 32'd0);
        snap_a = n_strobe_cyc;
        csr_wr(2'd0, 32'd1);
        csr_rd(2'd0, v); check("t2_ctrl", v, 32'h0000_0002);
        check("t2_no_strobe", n_strobe_cyc - snap_a, 32'd0);

        // Single pair with random stalls
        stall_en = 1'b1;
        run_batch(32'h140, 32'h900, 32'd1);
        wait_idle("t3_idle");
        check("t3_dst", dst_arr[576], 32'd12);
        csr_rd(2'd0, v); check("t3_ctrl", v, 32'h0001_0002);

        // Randomized batch with stalls against the Euclid reference
        for (int i = 0; i < 4; i++) begin
            pa[i] = $urandom_range(1, 5000);
            pb[i] = $urandom_range(1, 5000);
            src_arr[256 + 2*i]     = pa[i];
            src_arr[256 + 2*i + 1] = pb[i];
        end
        run_batch(32'h400, 32'hE00, 32'd4);
        wait_idle("t4_idle");
        for (int i = 0; i < 4; i++) check($sformatf("t4_dst%0d", i), dst_arr[896 + i], ref_gcd(pa[i], pb[i]));
        csr_rd(2'd0, v); check("t4_ctrl", v, 32'h0004_0002);
        stall_en = 1'b0;
        check("stall_stable", stall_viol, 32'd0);

        // Status stuck busy: abort with error after POLL_LIMIT polls
        stuck = 1'b1;
        snap_a = n_poll; snap_b = n_mem_wr;
        run_batch(32'h100, 32'hB00, 32'd2);
        wait_idle("t5_idle");
        csr_rd(2'd0, v); check("t5_ctrl", v, 32'h0000_0004);
        check("t5_polls", n_poll - snap_a, 32'd4);
        check("t5_no_dst_wr", n_mem_wr - snap_b, 32'd0);
        stuck = 1'b0;

        // Start and config writes while busy are ignored
        run_batch(32'h100, 32'hA00, 32'd3);
        csr_wr(2'd1, 32'h300);
        csr_wr(2'd0, 32'd1);
        csr_wr(2'd3, 32'd1);
        wait_idle("t6_idle");
        check("t6_dst0", dst_arr[640], 32'd6);
        check("t6_dst1", dst_arr[641], 32'd1);
        check("t6_dst2", dst_arr[642], 32'd250);
        csr_rd(2'd0, v); check("t6_ctrl", v, 32'h0003_0002);
        csr_rd(2'd1, v); check("t6_src", v, 32'h100);

        // Reset during POLL_WAIT, then a fresh batch
        stuck = 1'b1;
        run_batch(32'h140, 32'hC80, 32'd1);
        for (int i = 0; i < 300 && !gcd_read; i++) @(negedge clk);
        check("t7_poll_seen", {31'd0, gcd_read}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t7_strobes", {28'd0, mem_if.read, mem_if.write, gcd_read, gcd_write}, 32'd0);
        rst = 1'b0;
        stuck = 1'b0;
        csr_rd(2'd0, v); check("t7_ctrl", v, 32'd0);
        csr_rd(2'd1, v); check("t7_src", v, 32'd0);
        run_batch(32'h140, 32'hC00, 32'd1);
        wait_idle("t7_idle");
        check("t7_dst", dst_arr[768], 32'd12);
        csr_rd(2'd0, v); check("t7_ctrl_done", v, 32'h0001_0002);

        check("no_mem_gcd_overlap", overlap_viol, 32'd0);
        check("gcd_rw_exclusive", both_viol, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
